alu_issue_arbiter: RTL and testbench



---
 rtl/alu_issue_arbiter_pkg.sv | 18 +
 rtl/alu_issue_arbiter_tag_delay_line.sv | 42 ++++
 rtl/alu_issue_arbiter.sv | 125 ++++++++++++
 tb/tb_alu_issue_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_arbiter_pkg.sv
// Shared constants and owner-tag types for the ALU issue arbiter slice.
package alu_issue_arbiter_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_WIDTH   = 64;
    localparam int DEF_LATENCY = 7;
    localparam int DEF_MAX_OUT = 3;

    localparam int OWNER_W = (DEF_NREQ > 1) ? $clog2(DEF_NREQ) : 1;

    typedef logic [OWNER_W-1:0] owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;

endpackage

// File: rtl/alu_issue_arbiter_tag_delay_line.sv
// Fixed-depth shift register of {valid, owner} tags that travels alongside the
// shared unit's data stages; it never stalls.
module alu_issue_arbiter_tag_delay_line
    import alu_issue_arbiter_pkg::*;
#(
    parameter int DEPTH = DEF_LATENCY
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tag_valid,
    input  logic [OWNER_W-1:0] tag_owner,
    output logic               last_valid,
    output logic [OWNER_W-1:0] last_owner,
    output logic               any_valid
);

    tag_t stages [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= '{valid: tag_valid, owner: tag_owner};
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stages[i].valid;
        end
    end

    assign last_valid = stages[DEPTH-1].valid;
    assign last_owner = stages[DEPTH-1].owner;

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter sharing one fixed-latency pipelined unit among the
// cores, with a per-core cap on in-flight operations and tagged result return.
module alu_issue_arbiter
    import alu_issue_arbiter_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LATENCY = DEF_LATENCY,
    parameter int MAX_OUT = DEF_MAX_OUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       grant,
    output logic [WIDTH-1:0]      unit_in,
    output logic                  unit_in_valid,
    input  logic [WIDTH-1:0]      unit_out,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  busy
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [CNT_W-1:0] cnt [NREQ];
    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  cnt_nz;
    logic [NREQ-1:0]  rsp_done;
    owner_t           ptr;
    owner_t           win;
    owner_t           idx;
    owner_t           unit_in_owner;
    logic             found;
    logic [WIDTH-1:0] win_data;
    logic             tag_last_valid;
    owner_t           tag_last_owner;
    logic             tag_any_valid;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i]     = req[i] && (cnt[i] < CNT_W'(MAX_OUT));
            cnt_nz[i]   = (cnt[i] != '0);
            rsp_done[i] = tag_last_valid && (tag_last_owner == OWNER_W'(i));
        end
    end

    // Scan from the pointer and wrap; reset suppresses any accept.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = OWNER_W'((int'(ptr) + k) % NREQ);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (rst) begin
            found = 1'b0;
        end
        grant = '0;
        if (found) begin
            grant[win] = 1'b1;
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == OWNER_W'(i)) begin
                win_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= '0;
            unit_in       <= '0;
            unit_in_valid <= 1'b0;
            unit_in_owner <= '0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            for (int i = 0; i < NREQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            unit_in_valid <= found;
            if (found) begin
                unit_in       <= win_data;
                unit_in_owner <= win;
                ptr           <= OWNER_W'((int'(win) + 1) % NREQ);
            end
            rsp_valid <= rsp_done;
            if (tag_last_valid) begin
                rsp_data <= unit_out;
            end
            // A grant and a returning response for the same core cancel out.
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i] && !rsp_done[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (!grant[i] && rsp_done[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    alu_issue_arbiter_tag_delay_line #(
        .DEPTH (LATENCY)
    ) u_tags (
        .clk        (clk),
        .rst        (rst),
        .tag_valid  (unit_in_valid),
        .tag_owner  (unit_in_owner),
        .last_valid (tag_last_valid),
        .last_owner (tag_last_owner),
        .any_valid  (tag_any_valid)
    );

    assign busy = unit_in_valid | tag_any_valid | (|cnt_nz);

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed vectors with literal expectations plus a
// cycle-by-cycle comparison against a queue-based model of issued operations.
module tb_alu_issue_arbiter;

    localparam int N = 4;
    localparam int W = 64;
    localparam int L = 7;
    localparam int M = 3;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   grant;
    logic [W-1:0]   unit_in;
    logic           unit_in_valid;
    logic [W-1:0]   unit_out;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit model_ok = 1'b0;

    typedef struct {
        int           rcyc;
        int           owner;
        logic [W-1:0] data;
    } pend_t;

    pend_t        pend [$];
    int           m_ptr;
    int           m_cnt [N];
    logic         m_uiv;
    logic [W-1:0] m_unit_in;
    logic [N-1:0] m_rsp_valid;
    logic [W-1:0] m_rsp_data;

    alu_issue_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .grant         (grant),
        .unit_in       (unit_in),
        .unit_in_valid (unit_in_valid),
        .unit_out      (unit_out),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .busy          (busy)
    );

    // Shared unit: invert, then ripple through L register stages.
    logic [W-1:0] ustage [L];
    always @(posedge clk) begin
        ustage[0] <= ~unit_in;
        for (int i = 1; i < L; i++) begin
            ustage[i] <= ustage[i-1];
        end
    end
    assign unit_out = ustage[L-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [N-1:0] q);
        @(posedge clk);
        #1;
        rst = r;
        req = q;
        #1;
    endtask

    function automatic logic [N-1:0] expGrant();
        logic [N-1:0] g;
        g = '0;
        if (rst) return g;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (req[c] && m_cnt[c] < M) begin
                g[c] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // Model: every accepted operation is remembered with the cycle its result is due.
    task automatic modelStep();
        logic [N-1:0] g;
        int w;
        g = expGrant();
        w = -1;
        for (int i = 0; i < N; i++) begin
            if (g[i]) w = i;
        end
        if (rst) begin
            pend.delete();
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_ptr       = 0;
            m_uiv       = 1'b0;
            m_unit_in   = '0;
            m_rsp_valid = '0;
            m_rsp_data  = '0;
            model_ok    = 1'b1;
        end else begin
            m_rsp_valid = '0;
            if (pend.size() > 0 && pend[0].rcyc == cyc + 1) begin
                m_cnt[pend[0].owner]--;
                m_rsp_valid[pend[0].owner] = 1'b1;
                m_rsp_data = pend[0].data;
                void'(pend.pop_front());
            end
            m_uiv = (w >= 0);
            if (w >= 0) begin
                m_cnt[w]++;
                m_ptr     = (w + 1) % N;
                m_unit_in = req_data[w*W +: W];
                pend.push_back('{rcyc: cyc + L + 2, owner: w, data: ~req_data[w*W +: W]});
            end
        end
        cyc++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                checkOutput("grant", W'(grant), W'(expGrant()));
                checkOutput("unit_in_valid", W'(unit_in_valid), W'(m_uiv));
                checkOutput("unit_in", unit_in, m_unit_in);
                checkOutput("rsp_valid", W'(rsp_valid), W'(m_rsp_valid));
                checkOutput("rsp_data", rsp_data, m_rsp_data);
                checkOutput("busy", W'(busy), W'(pend.size() > 0));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: bench did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W] = {16{4'(i + 1)}};
        end

        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b1, 4'b0000);
        checkOutput("rst_grant", W'(grant), 64'h0);
        checkOutput("rst_unit_in", unit_in, 64'h0);
        checkOutput("rst_unit_in_valid", W'(unit_in_valid), 64'h0);
        checkOutput("rst_rsp_valid", W'(rsp_valid), 64'h0);
        checkOutput("rst_rsp_data", rsp_data, 64'h0);
        checkOutput("rst_busy", W'(busy), 64'h0);

        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, 4'b0000);
            checkOutput("idle_uiv", W'(unit_in_valid), 64'h0);
            checkOutput("idle_rsp", W'(rsp_valid), 64'h0);
            checkOutput("idle_busy", W'(busy), 64'h0);
        end

        // Single request from core 0.
        applyStimulus(1'b0, 4'b0001);
        checkOutput("single_grant", W'(grant), 64'h1);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("single_uiv", W'(unit_in_valid), 64'h1);
        checkOutput("single_unit_in", unit_in, 64'h1111111111111111);
        for (int k = 2; k <= 9; k++) begin
            applyStimulus(1'b0, 4'b0000);
            if (k == 8) checkOutput("single_rsp_early", W'(rsp_valid), 64'h0);
        end
        checkOutput("single_rsp_valid", W'(rsp_valid), 64'h1);
        checkOutput("single_rsp_data", rsp_data, 64'hEEEEEEEEEEEEEEEE);

        // Move pointer to 2, then check the wrap.
        applyStimulus(1'b0, 4'b0010);
        checkOutput("fair_setup", W'(grant), 64'h2);
        applyStimulus(1'b0, 4'b0011);
        checkOutput("fair_wrap", W'(grant), 64'h1);
        applyStimulus(1'b0, 4'b0011);
        checkOutput("fair_next", W'(grant), 64'h2);
        for (int k = 0; k < 12; k++) applyStimulus(1'b0, 4'b0000);
        checkOutput("fair_drained", W'(busy), 64'h0);

        // Core 2 alone hits its outstanding cap.
        req_data[2*W +: W] = 64'hDEADBEEF01234567;
        for (int k = 0; k <= 12; k++) begin
            applyStimulus(1'b0, 4'b0100);
            checkOutput("cap_grant", W'(grant),
                        (k < 3 || (k >= 9 && k <= 11)) ? 64'h4 : 64'h0);
            if (k == 9) begin
                checkOutput("cap_rsp_valid", W'(rsp_valid), 64'h4);
                checkOutput("cap_rsp_data", rsp_data, 64'h21524110FEDCBA98);
            end
        end
        for (int k = 0; k < 12; k++) applyStimulus(1'b0, 4'b0000);
        checkOutput("cap_drained", W'(busy), 64'h0);

        // Reset with five operations in flight.
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 4'b1111);
        applyStimulus(1'b1, 4'b1111);
        checkOutput("midrst_grant", W'(grant), 64'h0);
        applyStimulus(1'b0, 4'b1000);
        checkOutput("midrst_busy", W'(busy), 64'h0);
        checkOutput("midrst_uiv", W'(unit_in_valid), 64'h0);
        checkOutput("midrst_rsp", W'(rsp_valid), 64'h0);
        checkOutput("midrst_grant_after", W'(grant), 64'h8);
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(1'b0, 4'b0000);
            checkOutput("midrst_rsp_valid", W'(rsp_valid), (k == 9) ? 64'h8 : 64'h0);
        end
        checkOutput("midrst_rsp_data", rsp_data, 64'hBBBBBBBBBBBBBBBB);

        // All four cores requesting continuously.
        for (int k = 0; k < 30; k++) begin
            applyStimulus(1'b0, 4'b1111);
            if (k < 8) checkOutput("all_grant", W'(grant), 64'(1 << (k % 4)));
            if (k == 9) begin
                checkOutput("all_rsp0_valid", W'(rsp_valid), 64'h1);
                checkOutput("all_rsp0_data", rsp_data, 64'hEEEEEEEEEEEEEEEE);
            end
            if (k == 10) begin
                checkOutput("all_rsp1_valid", W'(rsp_valid), 64'h2);
                checkOutput("all_rsp1_data", rsp_data, 64'hDDDDDDDDDDDDDDDD);
            end
        end
        for (int k = 0; k < 12; k++) applyStimulus(1'b0, 4'b0000);
        checkOutput("all_drained", W'(busy), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
